feature_frame_sequencer: RTL and testbench

Parametrised successor to the single-channel feature shift register. It sequences an N-bit SAR ADC across up to NUM_FEAT analog channels and skips channels disabled by a runtime feature mask. Captured results are assembled into a frame and handed to the classifier through a valid/ready output buffer. The block sits between the analog mux/SAR front end and the classifier input register.

---
 rtl/feature_frame_sequencer_if.sv | 26 ++
 rtl/feature_frame_sequencer.sv | 148 ++++++++++++++
 tb/tb_feature_frame_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/feature_frame_sequencer_if.sv
// Handshake bundle between the SAR front end / classifier and the feature frame sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface feature_frame_sequencer_if #(
  parameter int N        = 4,
  parameter int NUM_FEAT = 8
);
  logic                  en;
  logic [NUM_FEAT-1:0]   feat_mask;
  logic [N-1:0]          quant_feat;
  logic                  frame_ready;
  logic                  sar_start;
  logic [NUM_FEAT-1:0]   feat_decoded;
  logic [NUM_FEAT*N-1:0] shift_reg;
  logic                  frame_valid;
  logic                  busy;

  modport master (
    output en, feat_mask, quant_feat, frame_ready,
    input  sar_start, feat_decoded, shift_reg, frame_valid, busy
  );

  modport slave (
    input  en, feat_mask, quant_feat, frame_ready,
    output sar_start, feat_decoded, shift_reg, frame_valid, busy
  );
endinterface

// File: rtl/feature_frame_sequencer.sv
// Sequences a SAR ADC over the channels enabled in a latched feature mask and
// hands the assembled frame to the classifier through a valid/ready buffer.
module feature_frame_sequencer #(
  parameter int N          = 4,
  parameter int SAR_CYCLES = 5,
  parameter int NUM_FEAT   = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  feature_frame_sequencer_if.slave      bus
);

  localparam int SCW = (SAR_CYCLES > 1) ? $clog2(SAR_CYCLES) : 1;
  localparam int IW  = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam logic [SCW-1:0] LastCnt = SCW'(SAR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [SCW-1:0]             sar_cnt_q, sar_cnt_d;
  logic [IW-1:0]              idx_q, idx_d;
  logic [NUM_FEAT-1:0]        mask_q, mask_d;
  logic [NUM_FEAT-1:0][N-1:0] cap_q, cap_d;
  logic [NUM_FEAT*N-1:0]      shift_q, shift_d;
  logic                       valid_q, valid_d;

  logic [IW-1:0]              first_idx;
  logic [IW-1:0]              next_idx;
  logic                       has_next;
  logic [NUM_FEAT*N-1:0]      frame_w;
  logic [NUM_FEAT-1:0]        decoded_w;

  // Downward scan so the lowest qualifying bit wins for both searches.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = NUM_FEAT - 1; i >= 0; i--) begin
      if (bus.feat_mask[i]) begin
        first_idx = IW'(i);
      end
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_idx = IW'(i);
        has_next = 1'b1;
      end
    end
  end

  always_comb begin
    frame_w = '0;
    for (int i = 0; i < NUM_FEAT; i++) begin
      if (mask_q[i]) begin
        frame_w[i*N +: N] = cap_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sar_cnt_d = sar_cnt_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    cap_d     = cap_q;
    shift_d   = shift_q;
    valid_d   = valid_q;

    if (valid_q && bus.frame_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.en && (|bus.feat_mask)) begin
          mask_d    = bus.feat_mask;
          idx_d     = first_idx;
          sar_cnt_d = '0;
          cap_d     = '0;
          state_d   = CONVERT;
        end
      end
      CONVERT: begin
        // Dropping en abandons the partial frame; the output buffer is left alone.
        if (!bus.en) begin
          sar_cnt_d = '0;
          state_d   = IDLE;
        end else if (sar_cnt_q == LastCnt) begin
          cap_d[idx_q] = bus.quant_feat;
          sar_cnt_d    = '0;
          if (has_next) begin
            idx_d = next_idx;
          end else begin
            state_d = DONE;
          end
        end else begin
          sar_cnt_d = sar_cnt_q + SCW'(1);
        end
      end
      DONE: begin
        if (!valid_q || bus.frame_ready) begin
          shift_d = frame_w;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      sar_cnt_q <= '0;
      idx_q     <= '0;
      mask_q    <= '0;
      cap_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sar_cnt_q <= sar_cnt_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      cap_q     <= cap_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    decoded_w = '0;
    if (state_q == CONVERT) begin
      decoded_w[idx_q] = 1'b1;
    end
  end

  assign bus.feat_decoded = decoded_w;
  assign bus.sar_start    = (state_q == CONVERT) && (sar_cnt_q == '0);
  assign bus.shift_reg    = shift_q;
  assign bus.frame_valid  = valid_q;
  assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_feature_frame_sequencer.sv
// Directed plus randomized frames against a schedule-level model of the sequencer,
// including a SAR_CYCLES=1 instance for the single-cycle conversion corner.
module tb_feature_frame_sequencer;

  localparam int S  = 5;
  localparam int NF = 4;

  logic clk;
  logic rst_ni;

  int   testCount = 0;
  int   failCount = 0;

  logic        expValid;
  logic [15:0] expShift;

  feature_frame_sequencer_if #(.N(4), .NUM_FEAT(NF)) bus ();
  feature_frame_sequencer_if #(.N(4), .NUM_FEAT(NF)) bus1 ();

  feature_frame_sequencer #(.N(4), .SAR_CYCLES(S), .NUM_FEAT(NF)) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  feature_frame_sequencer #(.N(4), .SAR_CYCLES(1), .NUM_FEAT(NF)) dut1 (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock; the model consumes the held frame when the handshake fires on this edge.
  task automatic step();
    logic consume;
    consume = expValid && (bus.frame_ready === 1'b1);
    @(posedge clk);
    #1;
    if (consume) expValid = 1'b0;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'(1'b0));
    checkOutput({tag, "_decoded"}, 64'(bus.feat_decoded), 64'(4'b0000));
    checkOutput({tag, "_sar_start"}, 64'(bus.sar_start), 64'(1'b0));
    checkOutput({tag, "_valid"}, 64'(bus.frame_valid), 64'(expValid));
    checkOutput({tag, "_shift"}, 64'(bus.shift_reg), 64'(expShift));
  endtask

  // mode 0: full frame, mode 1: drop en in CONVERT cycle atCyc, mode 2: reset in cycle atCyc.
  task automatic applyStimulus(input logic [3:0] m, input logic [15:0] data, input bit rdy,
                               input int mode, input int atCyc);
    int          chans[$];
    int          cyc;
    logic [15:0] frame;
    logic [3:0]  oneHot;
    chans = {};
    frame = '0;
    for (int c = 0; c < NF; c++) begin
      if (m[c]) begin
        chans.push_back(c);
        frame[c*4 +: 4] = data[c*4 +: 4];
      end
    end
    bus.en          = 1'b1;
    bus.feat_mask   = m;
    bus.frame_ready = rdy;
    step();
    cyc = 0;
    foreach (chans[j]) begin
      for (int k = 0; k < S; k++) begin
        cyc++;
        oneHot = 4'b0001 << chans[j];
        checkOutput("conv_decoded", 64'(bus.feat_decoded), 64'(oneHot));
        checkOutput("conv_sar_start", 64'(bus.sar_start), 64'(k == 0));
        checkOutput("conv_busy", 64'(bus.busy), 64'(1'b1));
        checkOutput("conv_valid", 64'(bus.frame_valid), 64'(expValid));
        bus.quant_feat = (k == S - 1) ? data[chans[j]*4 +: 4] : 4'($urandom);
        bus.feat_mask  = 4'($urandom);
        if (mode == 1 && cyc == atCyc) begin
          bus.en = 1'b0;
          step();
          checkIdleOutputs("abort");
          return;
        end
        if (mode == 2 && cyc == atCyc) begin
          rst_ni = 1'b0;
          step();
          rst_ni   = 1'b1;
          bus.en   = 1'b0;
          expValid = 1'b0;
          expShift = '0;
          checkIdleOutputs("midreset");
          return;
        end
        step();
      end
    end
    bus.en = 1'b0;
    checkOutput("done_decoded", 64'(bus.feat_decoded), 64'(4'b0000));
    checkOutput("done_sar_start", 64'(bus.sar_start), 64'(1'b0));
    checkOutput("done_busy", 64'(bus.busy), 64'(1'b1));
    checkOutput("done_valid", 64'(bus.frame_valid), 64'(expValid));
    checkOutput("done_shift", 64'(bus.shift_reg), 64'(expShift));
    if (expValid && !rdy) begin
      for (int h = 0; h < 3; h++) begin
        step();
        checkOutput("hold_busy", 64'(bus.busy), 64'(1'b1));
        checkOutput("hold_decoded", 64'(bus.feat_decoded), 64'(4'b0000));
        checkOutput("hold_valid", 64'(bus.frame_valid), 64'(1'b1));
        checkOutput("hold_shift", 64'(bus.shift_reg), 64'(expShift));
      end
      bus.frame_ready = 1'b1;
    end
    step();
    expValid = 1'b1;
    expShift = frame;
    checkOutput("load_valid", 64'(bus.frame_valid), 64'(1'b1));
    checkOutput("load_shift", 64'(bus.shift_reg), 64'(frame));
    checkOutput("load_busy", 64'(bus.busy), 64'(1'b0));
  endtask

  initial begin
    logic [15:0] d1;
    rst_ni           = 1'b0;
    expValid         = 1'b0;
    expShift         = '0;
    bus.en           = 1'b0;
    bus.feat_mask    = '0;
    bus.quant_feat   = '0;
    bus.frame_ready  = 1'b0;
    bus1.en          = 1'b0;
    bus1.feat_mask   = '0;
    bus1.quant_feat  = '0;
    bus1.frame_ready = 1'b0;
    step();
    step();
    rst_ni = 1'b1;
    checkIdleOutputs("reset");

    applyStimulus(4'b1111, 16'hFA53, 1'b1, 0, 0);
    applyStimulus(4'b0101, 16'hC9B7, 1'b1, 0, 0);
    checkOutput("mask0101_shift", 64'(bus.shift_reg), 64'(16'h0907));

    bus.frame_ready = 1'b1;
    step();
    applyStimulus(4'b0001, 16'h0002, 1'b0, 0, 0);
    applyStimulus(4'b0001, 16'h0006, 1'b0, 0, 0);
    checkOutput("backpressure_shift", 64'(bus.shift_reg), 64'(16'h0006));

    applyStimulus(4'b1111, 16'($urandom), 1'b1, 1, 7);
    applyStimulus(4'b1111, 16'($urandom), 1'b1, 2, 8);
    applyStimulus(4'b1010, 16'($urandom), 1'b1, 0, 0);

    bus.en        = 1'b1;
    bus.feat_mask = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      step();
      checkOutput("zeromask_sar_start", 64'(bus.sar_start), 64'(1'b0));
      checkOutput("zeromask_busy", 64'(bus.busy), 64'(1'b0));
    end
    bus.en = 1'b0;

    for (int r = 0; r < 6; r++) begin
      applyStimulus(4'($urandom_range(1, 15)), 16'($urandom), 1'($urandom), 0, 0);
    end

    d1               = 16'($urandom);
    bus1.en          = 1'b1;
    bus1.feat_mask   = 4'b1111;
    bus1.frame_ready = 1'b1;
    step();
    for (int c = 0; c < NF; c++) begin
      checkOutput("s1_decoded", 64'(bus1.feat_decoded), 64'(4'b0001 << c));
      checkOutput("s1_sar_start", 64'(bus1.sar_start), 64'(1'b1));
      bus1.quant_feat = d1[c*4 +: 4];
      step();
    end
    bus1.en = 1'b0;
    checkOutput("s1_done_valid", 64'(bus1.frame_valid), 64'(1'b0));
    checkOutput("s1_done_busy", 64'(bus1.busy), 64'(1'b1));
    step();
    checkOutput("s1_load_valid", 64'(bus1.frame_valid), 64'(1'b1));
    checkOutput("s1_load_shift", 64'(bus1.shift_reg), 64'(d1));

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
